// File: rtl/rx_serial_8n2_if.sv
// Interface between the serial receiver and its consumer: RX line in, received byte and status out.
// The slave modport is the receiver's view; master belongs to whoever drives the line and reads results.
interface rx_serial_8n2_if;
    logic       dado_serial;
    logic [7:0] dados_ascii;
    logic       pronto;
    logic       erro_framing;
    logic       erro_paridade;
    logic [3:0] db_estado;

    modport slave (
        input  dado_serial,
        output dados_ascii, pronto, erro_framing, erro_paridade, db_estado
    );

    modport master (
        output dado_serial,
        input  dados_ascii, pronto, erro_framing, erro_paridade, db_estado
    );
endinterface

// File: rtl/rx_serial_8n2.sv
// 8N2 asynchronous serial receiver (start, 8 data LSB first, 2 stop, idle high).
// Define RX_PARITY_EN to receive 8O2 frames with an odd-parity bit between the data and the stop bits.
module rx_serial_8n2 #(
    parameter int DIVISOR     = 434,
    parameter int LARGURA_CNT = 9
) (
    input  logic              clock,
    input  logic              reset,
    rx_serial_8n2_if.slave    bus
);
    localparam logic [LARGURA_CNT-1:0] CNT_LAST = LARGURA_CNT'(DIVISOR - 1);
    localparam logic [LARGURA_CNT-1:0] CNT_MID  = LARGURA_CNT'(DIVISOR / 2 - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        START_BIT = 4'h1,
        DADOS     = 4'h3,
`ifdef RX_PARITY_EN
        PARIDADE  = 4'h5,
`endif
        STOP1     = 4'h7,
        STOP2     = 4'hB,
        FINAL_RX  = 4'hF
    } estado_t;

    estado_t                state, next;
    logic [1:0]             sync;
    logic                   rx_s;
    logic [LARGURA_CNT-1:0] cnt_clk;
    logic [2:0]             cnt_bit;
    logic [7:0]             shift;
    logic                   flag_framing;
    logic [7:0]             dados_q;
    logic                   pronto_q;
    logic                   framing_q;
    logic                   clr_cnt, clr_bit, shift_en, stop_smp, load_out, clr_flag;

    // Two-flop synchronizer, preset to idle so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync <= 2'b11;
        else        sync <= {sync[0], bus.dado_serial};
    end
    assign rx_s = sync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        clr_cnt  = 1'b0;
        clr_bit  = 1'b0;
        shift_en = 1'b0;
        stop_smp = 1'b0;
        load_out = 1'b0;
        clr_flag = 1'b0;
        case (state)
            INICIAL: begin
                clr_cnt = 1'b1;
                if (!rx_s) next = START_BIT;
            end
            START_BIT: if (cnt_clk == CNT_MID) begin
                // Line back high at mid-start means a glitch, not a frame.
                clr_cnt = 1'b1;
                if (!rx_s) begin
                    next    = DADOS;
                    clr_bit = 1'b1;
                end else begin
                    next = INICIAL;
                end
            end
            DADOS: if (cnt_clk == CNT_LAST) begin
                clr_cnt  = 1'b1;
                shift_en = 1'b1;
`ifdef RX_PARITY_EN
                if (cnt_bit == 3'd7) next = PARIDADE;
`else
                if (cnt_bit == 3'd7) next = STOP1;
`endif
            end
`ifdef RX_PARITY_EN
            PARIDADE: if (cnt_clk == CNT_LAST) begin
                clr_cnt = 1'b1;
                next    = STOP1;
            end
`endif
            STOP1: if (cnt_clk == CNT_LAST) begin
                clr_cnt  = 1'b1;
                stop_smp = 1'b1;
                next     = STOP2;
            end
            // Outputs load on the last stop sample so they are valid while pronto is high.
            STOP2: if (cnt_clk == CNT_LAST) begin
                clr_cnt  = 1'b1;
                load_out = 1'b1;
                next     = FINAL_RX;
            end
            FINAL_RX: begin
                clr_cnt  = 1'b1;
                clr_flag = 1'b1;
                next     = INICIAL;
            end
            default: begin
                clr_cnt = 1'b1;
                next    = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_clk      <= '0;
            cnt_bit      <= '0;
            shift        <= '0;
            flag_framing <= 1'b0;
            dados_q      <= '0;
            pronto_q     <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            cnt_clk  <= clr_cnt ? '0 : cnt_clk + 1'b1;
            pronto_q <= load_out;
            if (clr_bit)       cnt_bit <= '0;
            else if (shift_en) cnt_bit <= cnt_bit + 3'd1;
            if (shift_en) shift <= {rx_s, shift[7:1]};
            if (clr_flag)                flag_framing <= 1'b0;
            else if (stop_smp && !rx_s)  flag_framing <= 1'b1;
            if (load_out) begin
                dados_q   <= shift;
                framing_q <= flag_framing | ~rx_s;
            end
        end
    end

`ifdef RX_PARITY_EN
    logic par_bit, paridade_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            par_bit    <= 1'b0;
            paridade_q <= 1'b0;
        end else begin
            if (state == PARIDADE && cnt_clk == CNT_LAST) par_bit <= rx_s;
            // Odd parity: an even count of ones across data+parity is an error.
            if (load_out) paridade_q <= ~(^shift ^ par_bit);
        end
    end
    assign bus.erro_paridade = paridade_q;
`else
    assign bus.erro_paridade = 1'b0;
`endif

    always_comb begin
        case (state)
            INICIAL, START_BIT, DADOS,
`ifdef RX_PARITY_EN
            PARIDADE,
`endif
            STOP1, STOP2, FINAL_RX: bus.db_estado = state;
            default:                bus.db_estado = 4'hE;
        endcase
    end

    assign bus.dados_ascii  = dados_q;
    assign bus.pronto       = pronto_q;
    assign bus.erro_framing = framing_q;
endmodule

// File: tb/tb_rx_serial_8n2.sv
// Directed bench for rx_serial_8n2 at DIVISOR=16: frames are driven bit by bit, expected results
// are queued on send and popped when pronto is seen.
module tb_rx_serial_8n2;
    localparam int DIV = 16;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rx_serial_8n2_if bus ();

    rx_serial_8n2 #(.DIVISOR(DIV), .LARGURA_CNT(5)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   pq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   start_cyc = 0;
    logic prev_pronto = 1'b0;
    logic saw_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.db_estado == 4'h1) saw_start = 1'b1;
        if (bus.pronto === 1'b1) begin
            pulses++;
            pq.push_back(cyc);
            chk("pronto_width", {31'd0, prev_pronto}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pronto", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dados_ascii", {24'd0, bus.dados_ascii}, {24'd0, e.d});
                chk("erro_framing", {31'd0, bus.erro_framing}, {31'd0, e.fe});
                chk("erro_paridade", {31'd0, bus.erro_paridade}, {31'd0, e.pe});
            end
        end
        prev_pronto = bus.pronto;
    endtask

    task automatic drive_bit(input logic v);
        bus.dado_serial = v;
        repeat (DIV) tick();
    endtask

    task automatic idle(input int n);
        bus.dado_serial = 1'b1;
        repeat (n) tick();
    endtask

    // p is the parity bit on the wire (only used when parity is compiled in).
    task automatic send_frame(input logic [7:0] d, input logic s2, input logic p);
        exp_t e;
        e.d  = d;
        e.fe = ~s2;
`ifdef RX_PARITY_EN
        e.pe = ~(^d ^ p);
`else
        e.pe = 1'b0;
`endif
        sb.push_back(e);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit(p);
`endif
        drive_bit(1'b1);
        drive_bit(s2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dados"}, {24'd0, bus.dados_ascii}, 32'd0);
        chk({tag, "_pronto"}, {31'd0, bus.pronto}, 32'd0);
        chk({tag, "_framing"}, {31'd0, bus.erro_framing}, 32'd0);
        chk({tag, "_paridade"}, {31'd0, bus.erro_paridade}, 32'd0);
        chk({tag, "_estado"}, {28'd0, bus.db_estado}, 32'd0);
    endtask

    initial begin
        int n;
        exp_t e;
        bus.dado_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(5);

        // Single clean frame and pronto latency from the falling edge.
        send_frame(8'h55, 1'b1, 1'b1);
        idle(10);
        chk("p55_pulses", 32'(pulses), 32'd1);
        if (pq.size() > 0) begin
            chk("p55_lat_lo", {31'd0, (pq[0] - start_cyc) >= 170}, 32'd1);
            chk("p55_lat_hi", {31'd0, (pq[0] - start_cyc) <= 174}, 32'd1);
        end else begin
            chk("p55_seen", 32'd0, 32'd1);
        end

        // Back-to-back frames without an idle gap.
        pq.delete();
        send_frame(8'h41, 1'b1, 1'b1);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(20);
        chk("b2b_pulses", 32'(pq.size()), 32'd2);
        if (pq.size() == 2) chk("b2b_spacing", 32'(pq[1] - pq[0]), 32'd176);

        // Second stop bit low, then a clean frame clears the error.
        send_frame(8'hA3, 1'b0, 1'b1);
        idle(20);
        send_frame(8'h10, 1'b1, 1'b0);
        idle(10);

        // Short glitch: enters start_bit, returns to inicial, nothing delivered.
        n = pulses;
        saw_start = 1'b0;
        bus.dado_serial = 1'b0;
        repeat (3) tick();
        idle(30);
        chk("glitch_saw_start", {31'd0, saw_start}, 32'd1);
        chk("glitch_pulses", 32'(pulses), 32'(n));
        chk("glitch_dados", {24'd0, bus.dados_ascii}, 32'h10);
        chk("glitch_estado", {28'd0, bus.db_estado}, 32'd0);

        // Reset in the middle of data bit 4 of 0xFF.
        n = pulses;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (DIV / 2) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        bus.dado_serial = 1'b1;
        repeat (5) tick();
        chk("midreset_hold_pronto", {31'd0, bus.pronto}, 32'd0);
        rst_n = 1'b1;
        idle(5);
        chk("abort_pulses", 32'(pulses), 32'(n));
        send_frame(8'h0F, 1'b1, 1'b1);
        idle(10);

        // Break: line held low gives repeated framing-error frames of 0x00.
        e.d  = 8'h00;
        e.fe = 1'b1;
`ifdef RX_PARITY_EN
        e.pe = 1'b1;
`else
        e.pe = 1'b0;
`endif
        sb.push_back(e);
        sb.push_back(e);
        n = pulses;
        bus.dado_serial = 1'b0;
        repeat (360) tick();
        chk("break_pulses", 32'(pulses - n), 32'd2);
        rst_n = 1'b0;
        bus.dado_serial = 1'b1;
        #1;
        rst_n = 1'b1;
        idle(10);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        chk("par_ok", {31'd0, bus.erro_paridade}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        chk("par_err", {31'd0, bus.erro_paridade}, 32'd1);
        chk("par_dados", {24'd0, bus.dados_ascii}, 32'h07);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_serial_8n2.md
Name: rx_serial_8n2

Overview:
- Asynchronous serial receiver for the 8N2 frame: 1 start bit, 8 data bits LSB first, no parity, 2 stop bits, line idle high.
- Sits directly downstream of the serial transmitter and consumes its TX line. The loopback is TX serial output → this block's RX input.
- Self-contained: internal bit-timing counter, input synchronizer, receive FSM and shift register.
- Delivers the received byte with a one-cycle `pronto` pulse.

Parameters:
- DIVISOR, 434, clock cycles per bit (50 MHz / 115200 baud); legal range ≥ 4, even values only.
- LARGURA_CNT, 9, width of the bit-timing counter; must satisfy 2^LARGURA_CNT > DIVISOR.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-low: reset = 0 forces the reset state immediately.
- dado_serial  in  1  RX line, asynchronous to clock, idle = 1.
- dados_ascii  out  8  last received byte, held until the next successful frame.
- pronto  out  1  one-cycle pulse when a frame completes.
- erro_framing  out  1  valid with `pronto`: 1 if either stop bit sampled as 0.
- erro_paridade  out  1  see Optional Feature.
- db_estado  out  4  current FSM state code, for debug.

Behaviour:

Reset values (while reset = 0):
- FSM = inicial.
- All counters = 0; shift register = 0.
- dados_ascii = 8'h00; pronto = 0; erro_framing = 0; erro_paridade = 0; db_estado = 4'h0.
- Synchronizer flops = 1, so the line reads as idle.

Input synchronization:
- dado_serial passes through a 2-flop synchronizer; all FSM decisions use the synchronized value `rx_s`.
- Latency: 2 cycles.

Counters:
- cnt_clk: 0..DIVISOR-1; cleared on every state entry.
- cnt_bit: 0..7.

FSM states (db_estado code):
- inicial (0):
  - Wait for rx_s = 0, then go to start_bit and clear cnt_clk.
- start_bit (1):
  - Count to DIVISOR/2 - 1 (mid-bit), then sample rx_s.
  - rx_s = 0 → dados; clear cnt_clk and cnt_bit.
  - rx_s = 1 → glitch: return to inicial with no outputs changed.
- dados (3):
  - At cnt_clk = DIVISOR-1, sample rx_s into the shift register: shift right, new bit enters at MSB (LSB-first wire order). Then increment cnt_bit and clear cnt_clk.
  - After the 8th sample (cnt_bit was 7) → paridade if RX_PARITY_EN is defined, else stop1.
- paridade (5):
  - At cnt_clk = DIVISOR-1, sample rx_s into the parity register → stop1.
- stop1 (7):
  - At cnt_clk = DIVISOR-1, sample; 0 sets an internal framing flag → stop2.
- stop2 (B):
  - At cnt_clk = DIVISOR-1, sample; 0 sets the framing flag → final_rx.
- final_rx (F):
  - Single cycle.
  - Registers update: dados_ascii ← shift register; erro_framing ← flag; erro_paridade ← parity result; pronto = 1.
  - Then → inicial and clear the internal flags.
- Illegal state codes → inicial; db_estado = E while in an illegal code.

Output timing and boundary rules:
- pronto is high for exactly one cycle per accepted frame.
- erro_framing and erro_paridade are held until the next final_rx.
- A frame with a framing error still updates dados_ascii. Downstream must qualify the byte with erro_framing.
- Back-to-back frames: the second stop bit is sampled mid-bit and the FSM re-enters inicial in time. A start bit arriving immediately after the second stop bit is received correctly, with no idle gap required.
- Line held low (break condition):
  - The frame completes with erro_framing = 1.
  - The FSM then re-triggers from inicial and yields repeated framing-error frames while the line stays low.
- Reset asserted mid-frame aborts immediately. No pronto is produced for the aborted frame.
- Sampling point: every data and stop sample is taken DIVISOR cycles after the previous one. The first data sample is 1.5 bit times after the synchronized falling edge.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Frame becomes 8O2: 8 data bits, odd parity, 2 stop bits.
  - The paridade state is present.
  - erro_paridade = 1 when the XOR of the 8 data bits and the parity bit equals 0.
- Undefined:
  - Frame is 8N2; the paridade state is not compiled.
  - erro_paridade is constant 0.
  - The port remains present in both builds.

Test Plan (DIVISOR = 16 for simulation):
- 8N2 frame 0x55 (bits 1,0,1,0,1,0,1,0 LSB first), stop bits = 1 → dados_ascii = 0x55; pronto pulses exactly once for 1 cycle, 170..174 clocks after the RX falling edge; erro_framing = 0.
- Back-to-back frames 0x41 then 0x7E with no idle gap → two pronto pulses 176 clocks apart (11 bits × 16); dados_ascii = 0x41, then 0x7E; no errors.
- Frame 0xA3 with the second stop bit driven 0 → dados_ascii = 0xA3, erro_framing = 1 with pronto. A following clean frame 0x10 → erro_framing = 0.
- 3-cycle low glitch on an idle line → FSM returns from start_bit to inicial; no pronto; dados_ascii unchanged.
- Reset pulled low at data bit 4 of frame 0xFF, released, then frame 0x0F sent → no pronto for the aborted frame; outputs at reset values during reset; next pronto yields 0x0F.
- RX_PARITY_EN defined: 0x07 with parity bit 0 → erro_paridade = 0. 0x07 with parity bit 1 → erro_paridade = 1 and dados_ascii = 0x07.
